// File: rtl/uart_debug_unit.sv
// UART debug controller: command decode, big-endian instruction loading, run/step gating and LSB-first state dump.
// Optional DEBUG_CHECKSUM_EN appends an XOR checksum byte to the dump frame.
module uart_debug_unit #(
    parameter int                DATA_W    = 8,
    parameter int                WORD_W    = 32,
    parameter int                ADDR_W    = 8,
    parameter int                DUMP_W    = 2554,
    parameter logic [WORD_W-1:0] HALT_WORD = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx_done,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_tx_done,
    input  logic [DUMP_W-1:0] i_dump,
    input  logic              i_mips_halted,
    output logic [DATA_W-1:0] o_data_send,
    output logic              o_tx_start,
    output logic              o_im_we,
    output logic [ADDR_W-1:0] o_im_addr,
    output logic [WORD_W-1:0] o_im_data,
    output logic              o_mips_en,
    output logic              o_load_full
);
    localparam int BPW   = WORD_W / DATA_W;
    localparam int BC_W  = $clog2(BPW + 1);
    localparam int NB    = (DUMP_W + DATA_W - 1) / DATA_W;
    localparam int PAD_W = NB * DATA_W;
`ifdef DEBUG_CHECKSUM_EN
    localparam int FRAME = NB + 1;
`else
    localparam int FRAME = NB;
`endif
    localparam int SH_W  = FRAME * DATA_W;
    localparam int SC_W  = $clog2(FRAME + 1);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [DATA_W-1:0] CMD_LOAD  = DATA_W'(1);
    localparam logic [DATA_W-1:0] CMD_RUN   = DATA_W'(2);
    localparam logic [DATA_W-1:0] CMD_STEP  = DATA_W'(3);
    localparam logic [DATA_W-1:0] CMD_DUMP  = DATA_W'(4);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_STEP, S_SNAP, S_SEND, S_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] word_buf;
    logic [BC_W-1:0]   byte_cnt;
    logic [SH_W-1:0]   shift_reg;
    logic [SC_W-1:0]   snd_cnt;

    logic [WORD_W-1:0] word_nxt;
    logic              word_done;
    logic [PAD_W-1:0]  dump_pad;
    logic [SH_W-1:0]   snap_val;

    assign word_nxt  = (word_buf << DATA_W) | WORD_W'(i_data);
    assign word_done = (state == S_LOAD) && i_rx_done && (byte_cnt == BC_W'(BPW - 1));
    assign dump_pad  = PAD_W'(i_dump);

`ifdef DEBUG_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    always_comb begin
        csum = '0;
        for (int i = 0; i < NB; i++) csum = csum ^ dump_pad[i*DATA_W +: DATA_W];
    end
    assign snap_val = {csum, dump_pad};
`else
    assign snap_val = dump_pad;
`endif

    assign o_data_send = shift_reg[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        o_mips_en  = 1'b0;
        o_tx_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_rx_done) begin
                    if      (i_data == CMD_LOAD) state_nxt = S_LOAD;
                    else if (i_data == CMD_RUN)  state_nxt = S_RUN;
                    else if (i_data == CMD_STEP) state_nxt = S_STEP;
                    else if (i_data == CMD_DUMP) state_nxt = S_SNAP;
                end
            end
            S_LOAD: begin
                if (word_done && (word_nxt == HALT_WORD || addr == ADDR_LAST))
                    state_nxt = S_IDLE;
            end
            S_RUN: begin
                o_mips_en = 1'b1;
                if (i_mips_halted) state_nxt = S_SNAP;
            end
            S_STEP: begin
                o_mips_en = 1'b1;
                state_nxt = S_SNAP;
            end
            S_SNAP: state_nxt = S_SEND;
            S_SEND: begin
                o_tx_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                // tx_done is only honoured here, so a pulse coinciding with tx_start is dropped
                if (i_tx_done) state_nxt = (snd_cnt == SC_W'(FRAME - 1)) ? S_IDLE : S_SEND;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr        <= '0;
            word_buf    <= '0;
            byte_cnt    <= '0;
            shift_reg   <= '0;
            snd_cnt     <= '0;
            o_im_we     <= 1'b0;
            o_im_addr   <= '0;
            o_im_data   <= '0;
            o_load_full <= 1'b0;
        end else begin
            o_im_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_rx_done && i_data == CMD_LOAD) begin
                        addr        <= '0;
                        word_buf    <= '0;
                        byte_cnt    <= '0;
                        o_load_full <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (word_done) begin
                        o_im_we   <= 1'b1;
                        o_im_addr <= addr;
                        o_im_data <= word_nxt;
                        word_buf  <= '0;
                        byte_cnt  <= '0;
                        // saturate at the top of memory instead of wrapping
                        if (addr == ADDR_LAST) o_load_full <= 1'b1;
                        else                   addr <= addr + 1'b1;
                    end else if (i_rx_done) begin
                        word_buf <= word_nxt;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                S_SNAP: begin
                    shift_reg <= snap_val;
                    snd_cnt   <= '0;
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        shift_reg <= shift_reg >> DATA_W;
                        snd_cnt   <= snd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_debug_unit.sv
// Directed self-checking bench for uart_debug_unit (small memory and dump widths).
module tb_uart_debug_unit;
    localparam int DATA_W = 8;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 2;
    localparam int DUMP_W = 16;
`ifdef DEBUG_CHECKSUM_EN
    localparam int FR = 3;
`else
    localparam int FR = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_rx_done = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_tx_done = 1'b0;
    logic [DUMP_W-1:0] i_dump = 16'h3CA5;
    logic              i_mips_halted = 1'b0;
    logic [DATA_W-1:0] o_data_send;
    logic              o_tx_start;
    logic              o_im_we;
    logic [ADDR_W-1:0] o_im_addr;
    logic [WORD_W-1:0] o_im_data;
    logic              o_mips_en;
    logic              o_load_full;

    uart_debug_unit #(
        .DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .DUMP_W(DUMP_W)
    ) dut (
        .clk(clk), .rst(rst),
        .i_rx_done(i_rx_done), .i_data(i_data),
        .i_tx_done(i_tx_done), .i_dump(i_dump), .i_mips_halted(i_mips_halted),
        .o_data_send(o_data_send), .o_tx_start(o_tx_start),
        .o_im_we(o_im_we), .o_im_addr(o_im_addr), .o_im_data(o_im_data),
        .o_mips_en(o_mips_en), .o_load_full(o_load_full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // event log sampled on the falling edge
    int              wr_n = 0, en_n = 0, tx_n = 0;
    logic [ADDR_W-1:0] wr_a [32];
    logic [WORD_W-1:0] wr_d [32];
    logic [DATA_W-1:0] tx_b [32];

    always @(negedge clk) begin
        if (o_im_we) begin
            wr_a[wr_n % 32] <= o_im_addr;
            wr_d[wr_n % 32] <= o_im_data;
            wr_n <= wr_n + 1;
        end
        if (o_mips_en) en_n <= en_n + 1;
        if (o_tx_start) begin
            tx_b[tx_n % 32] <= o_data_send;
            tx_n <= tx_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_done = 1'b1;
        i_data    = b;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic ack_byte(input string tag);
        int t = 0;
        while (!o_tx_start && t < 50) begin
            tick();
            t++;
        end
        chk(tag, 64'(o_tx_start), 64'd1);
        tick();
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    int wb, eb, tb;
    logic [7:0] ld1 [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h80, 8'h40, 8'hC0, 8'h20,
                             8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] ld2 [20] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80,
                             8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'h11,
                             8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] ld3 [8]  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    initial begin
        // reset
        tick();
        tick();
        chk("rst_we", 64'(o_im_we), 64'd0);
        chk("rst_addr", 64'(o_im_addr), 64'd0);
        chk("rst_data", 64'(o_im_data), 64'd0);
        chk("rst_en", 64'(o_mips_en), 64'd0);
        chk("rst_txs", 64'(o_tx_start), 64'd0);
        chk("rst_send", 64'(o_data_send), 64'd0);
        chk("rst_full", 64'(o_load_full), 64'd0);
        rst = 1'b1;
        tick();
        chk("idle_en", 64'(o_mips_en), 64'd0);
        chk("idle_txs", 64'(o_tx_start), 64'd0);

        // LOAD of two words plus halt word, back-to-back bytes
        wb = wr_n;
        send(8'h01);
        foreach (ld1[i]) send(ld1[i]);
        tick();
        tick();
        chk("ld_cnt", 64'(wr_n - wb), 64'd3);
        chk("ld_a0", 64'(wr_a[(wb + 0) % 32]), 64'd0);
        chk("ld_d0", 64'(wr_d[(wb + 0) % 32]), 64'h01020304);
        chk("ld_a1", 64'(wr_a[(wb + 1) % 32]), 64'd1);
        chk("ld_d1", 64'(wr_d[(wb + 1) % 32]), 64'h8040C020);
        chk("ld_a2", 64'(wr_a[(wb + 2) % 32]), 64'd2);
        chk("ld_d2", 64'(wr_d[(wb + 2) % 32]), 64'hFFFFFFFF);
        chk("ld_full", 64'(o_load_full), 64'd0);

        // STEP (also proves LOAD returned to IDLE)
        eb = en_n;
        tb = tx_n;
        send(8'h03);
        chk("st_en1", 64'(o_mips_en), 64'd1);
        tick();
        chk("st_en0", 64'(o_mips_en), 64'd0);
        chk("st_snap_txs", 64'(o_tx_start), 64'd0);
        tick();
        chk("st_txs0", 64'(o_tx_start), 64'd1);
        chk("st_b0", 64'(o_data_send), 64'hA5);
        tick();
        chk("st_wait_txs", 64'(o_tx_start), 64'd0);
        tick();
        tick();
        chk("st_hold", 64'(o_data_send), 64'hA5);
        chk("st_hold_txs", 64'(o_tx_start), 64'd0);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        chk("st_txs1", 64'(o_tx_start), 64'd1);
        chk("st_b1", 64'(o_data_send), 64'h3C);
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
`ifdef DEBUG_CHECKSUM_EN
        chk("st_txs2", 64'(o_tx_start), 64'd1);
        chk("st_csum", 64'(o_data_send), 64'h99);
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
`endif
        tick();
        chk("st_en_cnt", 64'(en_n - eb), 64'd1);
        chk("st_tx_cnt", 64'(tx_n - tb), 64'(FR));

        // RUN, halt raised after 10 enabled cycles
        eb = en_n;
        tb = tx_n;
        send(8'h02);
        chk("run_en", 64'(o_mips_en), 64'd1);
        repeat (9) tick();
        chk("run_en9", 64'(o_mips_en), 64'd1);
        i_mips_halted = 1'b1;
        tick();
        chk("run_en_off", 64'(o_mips_en), 64'd0);
        chk("run_en_cnt", 64'(en_n - eb), 64'd10);
        for (int i = 0; i < FR; i++) ack_byte("run_txs");
        tick();
        i_mips_halted = 1'b0;
        chk("run_tx_cnt", 64'(tx_n - tb), 64'(FR));
        chk("run_b0", 64'(tx_b[(tb + 0) % 32]), 64'hA5);
        chk("run_b1", 64'(tx_b[(tb + 1) % 32]), 64'h3C);
`ifdef DEBUG_CHECKSUM_EN
        chk("run_csum", 64'(tx_b[(tb + 2) % 32]), 64'h99);
`endif

        // LOAD overflow with 4-entry memory
        wb = wr_n;
        send(8'h01);
        foreach (ld2[i]) send(ld2[i]);
        tick();
        tick();
        chk("of_cnt", 64'(wr_n - wb), 64'd4);
        chk("of_a0", 64'(wr_a[(wb + 0) % 32]), 64'd0);
        chk("of_d0", 64'(wr_d[(wb + 0) % 32]), 64'h10203040);
        chk("of_a3", 64'(wr_a[(wb + 3) % 32]), 64'd3);
        chk("of_d3", 64'(wr_d[(wb + 3) % 32]), 64'hD0E0F011);
        chk("of_full", 64'(o_load_full), 64'd1);
        chk("of_addr", 64'(o_im_addr), 64'd3);
        chk("of_idle_en", 64'(o_mips_en), 64'd0);
        chk("of_idle_txs", 64'(o_tx_start), 64'd0);

        // reset mid-word discards the partial word
        wb = wr_n;
        send(8'h01);
        send(8'hAA);
        send(8'hBB);
        rst = 1'b0;
        tick();
        chk("mr_full", 64'(o_load_full), 64'd0);
        chk("mr_addr", 64'(o_im_addr), 64'd0);
        chk("mr_nowr", 64'(wr_n - wb), 64'd0);
        rst = 1'b1;
        tick();
        wb = wr_n;
        send(8'h01);
        foreach (ld3[i]) send(ld3[i]);
        tick();
        tick();
        chk("mr_cnt", 64'(wr_n - wb), 64'd2);
        chk("mr_a0", 64'(wr_a[(wb + 0) % 32]), 64'd0);
        chk("mr_d0", 64'(wr_d[(wb + 0) % 32]), 64'h12345678);
        chk("mr_a1", 64'(wr_a[(wb + 1) % 32]), 64'd1);

        // DUMP with tx_done withheld; a tx_done coinciding with tx_start is ignored
        i_dump = 16'h1234;
        tb = tx_n;
        send(8'h04);
        tick();
        chk("dp_txs", 64'(o_tx_start), 64'd1);
        chk("dp_b0", 64'(o_data_send), 64'h34);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        repeat (30) tick();
        chk("dp_tx_cnt", 64'(tx_n - tb), 64'd1);
        chk("dp_hold", 64'(o_data_send), 64'h34);
        chk("dp_txs_low", 64'(o_tx_start), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
